// File: rtl/gpio_input_conditioner_if.sv
// rtl/gpio_input_conditioner_if.sv - pad-side and controller-side signals of the GPIO input conditioner
`ifndef GPIO_WIDTH
`define GPIO_WIDTH 8
`endif

interface gpio_input_conditioner_if #(
    parameter int WIDTH    = `GPIO_WIDTH,
    parameter int DB_CNT_W = 16
);
    logic [WIDTH-1:0]    pad_i;
    logic [WIDTH-1:0]    db_en;
    logic [DB_CNT_W-1:0] db_limit;
    logic [WIDTH-1:0]    i;
    logic [WIDTH-1:0]    rise;
    logic [WIDTH-1:0]    fall;

    modport master (
        output pad_i, db_en, db_limit,
        input  i, rise, fall
    );

    modport slave (
        input  pad_i, db_en, db_limit,
        output i, rise, fall
    );
endinterface

// File: rtl/gpio_input_conditioner.sv
// rtl/gpio_input_conditioner.sv - per-bit synchronizer, optional debounce and registered edge pulses
`ifndef GPIO_WIDTH
`define GPIO_WIDTH 8
`endif

module gpio_input_conditioner #(
    parameter int WIDTH       = `GPIO_WIDTH,
    parameter int SYNC_STAGES = 2,
    parameter int DB_CNT_W    = 16
) (
    input  logic                          clk,
    input  logic                          rstn,
    gpio_input_conditioner_if.slave       bus
);

    logic [WIDTH-1:0]    r_sync [SYNC_STAGES];
    logic [WIDTH-1:0]    r_s;
    logic [DB_CNT_W-1:0] r_cnt [WIDTH];
    logic [WIDTH-1:0]    r_rise;
    logic [WIDTH-1:0]    r_fall;

    logic [WIDTH-1:0]    w_y;
    logic [WIDTH-1:0]    w_s_next;
    logic [DB_CNT_W-1:0] w_cnt_next [WIDTH];
    logic [DB_CNT_W-1:0] w_limit;
    logic [DB_CNT_W-1:0] w_limit_m1;

    assign w_y        = r_sync[SYNC_STAGES-1];
    assign w_limit    = (bus.db_limit == '0) ? DB_CNT_W'(1) : bus.db_limit;
    assign w_limit_m1 = w_limit - DB_CNT_W'(1);

    // The >= compare lets a lowered limit accept immediately and keeps the counter from wrapping.
    always_comb begin
        w_s_next = r_s;
        for (int k = 0; k < WIDTH; k++) begin
            w_cnt_next[k] = r_cnt[k];
            if (!bus.db_en[k]) begin
                w_s_next[k]   = w_y[k];
                w_cnt_next[k] = '0;
            end else if (w_y[k] == r_s[k]) begin
                w_cnt_next[k] = '0;
            end else if (r_cnt[k] >= w_limit_m1) begin
                w_s_next[k]   = w_y[k];
                w_cnt_next[k] = '0;
            end else begin
                w_cnt_next[k] = r_cnt[k] + DB_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int j = 0; j < SYNC_STAGES; j++) begin
                r_sync[j] <= '0;
            end
            for (int k = 0; k < WIDTH; k++) begin
                r_cnt[k] <= '0;
            end
            r_s    <= '0;
            r_rise <= '0;
            r_fall <= '0;
        end else begin
            r_sync[0] <= bus.pad_i;
            for (int j = 1; j < SYNC_STAGES; j++) begin
                r_sync[j] <= r_sync[j-1];
            end
            for (int k = 0; k < WIDTH; k++) begin
                r_cnt[k] <= w_cnt_next[k];
            end
            r_s    <= w_s_next;
            r_rise <= w_s_next & ~r_s;
            r_fall <= ~w_s_next & r_s;
        end
    end

    assign bus.i    = r_s;
    assign bus.rise = r_rise;
    assign bus.fall = r_fall;

endmodule

// File: tb/tb_gpio_input_conditioner.sv
// tb/tb_gpio_input_conditioner.sv - directed latency checks plus randomized comparison against a run-length model
module tb_gpio_input_conditioner;

    localparam int W    = 8;
    localparam int SYNC = 2;
    localparam int CW   = 16;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   n_cmp  = 0;
    int   n_fail = 0;

    gpio_input_conditioner_if #(.WIDTH(W), .DB_CNT_W(CW)) bus ();

    gpio_input_conditioner #(.WIDTH(W), .SYNC_STAGES(SYNC), .DB_CNT_W(CW)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Model: pad samples travel through a SYNC-deep queue; a debounced bit flips once y has
    // disagreed with it for L consecutive samples.
    logic [W-1:0] m_q[$];
    logic [W-1:0] m_s, m_rise, m_fall;
    int           m_run [W];

    task automatic model_reset();
        m_q = {};
        for (int j = 0; j < SYNC; j++) m_q.push_back('0);
        m_s = '0; m_rise = '0; m_fall = '0;
        for (int k = 0; k < W; k++) m_run[k] = 0;
    endtask

    task automatic model_step();
        logic [W-1:0] y, ns;
        int lim;
        y   = m_q[0];
        ns  = m_s;
        lim = (bus.db_limit == 0) ? 1 : int'(bus.db_limit);
        for (int k = 0; k < W; k++) begin
            if (!bus.db_en[k]) begin
                ns[k] = y[k]; m_run[k] = 0;
            end else if (y[k] == m_s[k]) begin
                m_run[k] = 0;
            end else if (m_run[k] + 1 >= lim) begin
                ns[k] = y[k]; m_run[k] = 0;
            end else begin
                m_run[k] = m_run[k] + 1;
            end
        end
        m_rise = ns & ~m_s;
        m_fall = ~ns & m_s;
        m_s    = ns;
        void'(m_q.pop_front());
        m_q.push_back(bus.pad_i);
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rstn) model_reset();
        else       model_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        bus.pad_i = '0; bus.db_en = '0; bus.db_limit = '0;
        model_reset();
        tick(); tick();
        rstn = 1'b1;
    endtask

    // Runs n edges on bit k; drops the pad before edge drop_at and loads lim_val before edge lim_at.
    task automatic watch(input int k, input int n, input int drop_at, input int lim_at, input int lim_val,
                         output int first_hi, output int first_lo, output int first_r, output int nr, output int nf);
        first_hi = -1; first_lo = -1; first_r = -1; nr = 0; nf = 0;
        for (int e = 1; e <= n; e++) begin
            if (e == drop_at) bus.pad_i[k] = 1'b0;
            if (e == lim_at)  bus.db_limit = CW'(lim_val);
            tick();
            if (bus.i[k] && first_hi < 0) first_hi = e;
            if (!bus.i[k] && first_hi >= 0 && first_lo < 0) first_lo = e;
            if (bus.rise[k]) begin nr++; if (first_r < 0) first_r = e; end
            if (bus.fall[k]) nf++;
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        bus.pad_i = '1; bus.db_en = '0; bus.db_limit = '0;
        model_reset();
        tick(); tick();
        n_cmp++; if (bus.i !== '0)    begin n_fail++; $display("FAIL reset_i: got %h want 00", bus.i); end
        n_cmp++; if (bus.rise !== '0) begin n_fail++; $display("FAIL reset_rise: got %h want 00", bus.rise); end
        n_cmp++; if (bus.fall !== '0) begin n_fail++; $display("FAIL reset_fall: got %h want 00", bus.fall); end
    endtask

    task automatic test_bypass();
        int fh, fl, fr, nr, nf;
        do_reset();
        bus.pad_i[0] = 1'b1;
        watch(0, 10, 5, -1, 0, fh, fl, fr, nr, nf);
        n_cmp++; if (fh !== 3) begin n_fail++; $display("FAIL bypass_i_edge: got %0d want 3", fh); end
        n_cmp++; if (fr !== 3 || nr !== 1) begin n_fail++; $display("FAIL bypass_rise: edge %0d count %0d want edge 3 count 1", fr, nr); end
        n_cmp++; if (fl !== 7 || nf !== 1) begin n_fail++; $display("FAIL bypass_fall: edge %0d count %0d want edge 7 count 1", fl, nf); end
    endtask

    task automatic test_debounce_accept();
        int fh, fl, fr, nr, nf;
        do_reset();
        bus.db_en[1] = 1'b1; bus.db_limit = 16'd5;
        bus.pad_i[1] = 1'b1;
        watch(1, 12, -1, -1, 0, fh, fl, fr, nr, nf);
        n_cmp++; if (fh !== 7) begin n_fail++; $display("FAIL debounce_i_edge: got %0d want 7", fh); end
        n_cmp++; if (fr !== 7 || nr !== 1) begin n_fail++; $display("FAIL debounce_rise: edge %0d count %0d want edge 7 count 1", fr, nr); end
    endtask

    task automatic test_glitch();
        int fh, fl, fr, nr, nf;
        do_reset();
        bus.db_en[2] = 1'b1; bus.db_limit = 16'd5;
        bus.pad_i[2] = 1'b1;
        watch(2, 14, 5, -1, 0, fh, fl, fr, nr, nf);
        n_cmp++; if (fh !== -1 || nr !== 0 || nf !== 0) begin n_fail++; $display("FAIL glitch_reject: i edge %0d rise %0d fall %0d want -1 0 0", fh, nr, nf); end
        bus.pad_i[2] = 1'b1;
        watch(2, 16, 6, -1, 0, fh, fl, fr, nr, nf);
        n_cmp++; if (fh !== 7) begin n_fail++; $display("FAIL glitch_accept_edge: got %0d want 7", fh); end
        n_cmp++; if (fl !== 12 || nr !== 1 || nf !== 1) begin n_fail++; $display("FAIL glitch_accept_fall: edge %0d rise %0d fall %0d want 12 1 1", fl, nr, nf); end
    endtask

    task automatic test_limits();
        int fh, fl, fr, nr, nf;
        do_reset();
        bus.db_en[3] = 1'b1; bus.db_limit = 16'd0;
        bus.pad_i[3] = 1'b1;
        watch(3, 6, -1, -1, 0, fh, fl, fr, nr, nf);
        n_cmp++; if (fh !== 3 || fr !== 3) begin n_fail++; $display("FAIL limit0_edge: i %0d rise %0d want 3 3", fh, fr); end
        do_reset();
        bus.db_en[3] = 1'b1; bus.db_limit = 16'd1;
        bus.pad_i[3] = 1'b1;
        watch(3, 6, -1, -1, 0, fh, fl, fr, nr, nf);
        n_cmp++; if (fh !== 3 || fr !== 3) begin n_fail++; $display("FAIL limit1_edge: i %0d rise %0d want 3 3", fh, fr); end
        do_reset();
        bus.db_en[4] = 1'b1; bus.db_limit = 16'd100;
        bus.pad_i[4] = 1'b1;
        watch(4, 16, -1, 13, 3, fh, fl, fr, nr, nf);
        n_cmp++; if (fh !== 13 || nr !== 1) begin n_fail++; $display("FAIL limit_lowered: edge %0d rise %0d want 13 1", fh, nr); end
    endtask

    task automatic test_reset_midcount();
        int fh, fl, fr, nr, nf;
        do_reset();
        bus.db_en[5] = 1'b1; bus.db_limit = 16'd8;
        bus.pad_i[5] = 1'b1;
        watch(5, 8, -1, -1, 0, fh, fl, fr, nr, nf);
        n_cmp++; if (fh !== -1) begin n_fail++; $display("FAIL midcount_early: got %0d want -1", fh); end
        rstn = 1'b0;
        model_reset();
        #1;
        n_cmp++; if (bus.i !== '0 || bus.rise !== '0) begin n_fail++; $display("FAIL midcount_async: i %h rise %h want 00 00", bus.i, bus.rise); end
        tick();
        rstn = 1'b1;
        watch(5, 14, -1, -1, 0, fh, fl, fr, nr, nf);
        n_cmp++; if (fh !== 10 || fr !== 10 || nr !== 1) begin n_fail++; $display("FAIL midcount_release: i %0d rise %0d count %0d want 10 10 1", fh, fr, nr); end
    endtask

    task automatic test_random();
        do_reset();
        bus.db_en    = W'($urandom);
        bus.db_limit = CW'($urandom_range(0, 6));
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < W; k++)
                if ($urandom_range(0, 7) == 0) bus.pad_i[k] = ~bus.pad_i[k];
            if ($urandom_range(0, 199) == 0) bus.db_en    = W'($urandom);
            if ($urandom_range(0, 149) == 0) bus.db_limit = CW'($urandom_range(0, 7));
            tick();
            n_cmp++; if (bus.i !== m_s)       begin n_fail++; $display("FAIL rand_i cyc %0d: got %h want %h", c, bus.i, m_s); end
            n_cmp++; if (bus.rise !== m_rise) begin n_fail++; $display("FAIL rand_rise cyc %0d: got %h want %h", c, bus.rise, m_rise); end
            n_cmp++; if (bus.fall !== m_fall) begin n_fail++; $display("FAIL rand_fall cyc %0d: got %h want %h", c, bus.fall, m_fall); end
            n_cmp++; if ((bus.rise & bus.fall) !== '0) begin n_fail++; $display("FAIL rand_exclusive cyc %0d: got %h want 00", c, bus.rise & bus.fall); end
        end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_debounce_accept();
        test_glitch();
        test_limits();
        test_reset_midcount();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
